// File: rtl/mem_access_sched.sv
// mem_access_sched: sequences the shared MAR and memory port between fetch (f_) and data (d_) requesters.
// Optional macro MEM_SCHED_DATA_PRIORITY_EN selects fixed data-over-fetch priority instead of round-robin.
module mem_access_sched #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 8,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              mar_we,
    output logic [ADDR_W-1:0] mar_in,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t            state_q;
    logic              last_d_q;
    logic              own_d_q;
    logic              we_q;
    logic [2:0]        cnt_q;
    logic [DATA_W-1:0] wdata_q;

    logic              f_ack_q;
    logic              d_ack_q;
    logic [DATA_W-1:0] rdata_q;
    logic              mar_we_q;
    logic [ADDR_W-1:0] mar_in_q;
    logic              mem_we_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              busy_q;

    logic              pick_data_s;

    // Arbitration winner among the requests present this cycle
    always_comb begin
        pick_data_s = 1'b0;
`ifdef MEM_SCHED_DATA_PRIORITY_EN
        pick_data_s = d_req;
`else
        if (d_req && f_req) begin
            pick_data_s = ~last_d_q;
        end else begin
            pick_data_s = d_req;
        end
`endif
    end

    // Access sequencer: IDLE -> LOAD -> ACCESS x MEM_LAT -> RESP, all outputs registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            last_d_q    <= 1'b0;
            own_d_q     <= 1'b0;
            we_q        <= 1'b0;
            cnt_q       <= 3'd0;
            wdata_q     <= '0;
            f_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            rdata_q     <= '0;
            mar_we_q    <= 1'b0;
            mar_in_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            f_ack_q  <= 1'b0;
            d_ack_q  <= 1'b0;
            mar_we_q <= 1'b0;
            mem_we_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (f_req || d_req) begin
                        own_d_q  <= pick_data_s;
                        last_d_q <= pick_data_s;
                        we_q     <= pick_data_s & d_we;
                        wdata_q  <= d_wdata;
                        mar_in_q <= pick_data_s ? d_addr : f_addr;
                        mar_we_q <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= S_LOAD;
                    end else begin
                        busy_q   <= 1'b0;
                    end
                end
                S_LOAD: begin
                    cnt_q       <= 3'(MEM_LAT);
                    mem_we_q    <= we_q;
                    mem_wdata_q <= wdata_q;
                    state_q     <= S_ACCESS;
                end
                S_ACCESS: begin
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        if (!we_q) begin
                            rdata_q <= mem_rdata;
                        end else begin
                            rdata_q <= rdata_q;
                        end
                        f_ack_q <= ~own_d_q;
                        d_ack_q <= own_d_q;
                        state_q <= S_RESP;
                    end else begin
                        state_q <= S_ACCESS;
                    end
                end
                S_RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign f_ack     = f_ack_q;
    assign d_ack     = d_ack_q;
    assign rdata     = rdata_q;
    assign mar_we    = mar_we_q;
    assign mar_in    = mar_in_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule
